// File: rtl/risc_irq_ctrl_if.sv
// Control-unit facing bundle of the interrupt controller: request lines,
// configuration port and the PC/vector handshake.
interface risc_irq_ctrl_if #(
  parameter int N_IRQ  = 8,
  parameter int ADDR_W = 32,
  parameter int ID_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  logic [N_IRQ-1:0]  irq;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       cfg_rdata;
  logic              at_boundary;
  logic [ADDR_W-1:0] pc_next;
  logic              int_ack;
  logic              reti;
  logic              int_req;
  logic [ADDR_W-1:0] vec_pc;
  logic [ADDR_W-1:0] epc;
  logic [ID_W-1:0]   irq_id;
  logic              in_service;

  modport master (
    output irq, cfg_we, cfg_addr, cfg_wdata, at_boundary, pc_next, int_ack, reti,
    input  cfg_rdata, int_req, vec_pc, epc, irq_id, in_service
  );

  modport slave (
    input  irq, cfg_we, cfg_addr, cfg_wdata, at_boundary, pc_next, int_ack, reti,
    output cfg_rdata, int_req, vec_pc, epc, irq_id, in_service
  );
endinterface

// File: rtl/risc_irq_ctrl.sv
// N-channel vectored interrupt controller: synchronises and latches requests,
// resolves fixed priority and runs the request/ack/return handshake with the core.
module risc_irq_ctrl #(
  parameter int          N_IRQ     = 8,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0040,
  parameter int          VEC_SHIFT = 4,
  parameter int          ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  risc_irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e            state_q;
  logic [N_IRQ-1:0]  s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0]  mask_q, mode_q, pend_q, pend_d;
  logic [N_IRQ-1:0]  eligible, w1c, ackClr;
  logic              gie_q, pgie_q, gieWr, pgieWr;
  logic              ackFire, ctrlWr;
  logic [ID_W-1:0]   winner, irqId_q;
  logic [ADDR_W-1:0] vecPc_q, epc_q;
  logic              intReq_q, inService_q;
  logic              unusedWdata;

  assign unusedWdata = ^bus.cfg_wdata;

  assign ackFire  = (state_q == REQ) && bus.int_ack;
  assign eligible = pend_q & mask_q;
  assign ctrlWr   = bus.cfg_we && (bus.cfg_addr == 2'd3);
  assign w1c      = (bus.cfg_we && (bus.cfg_addr == 2'd2)) ? bus.cfg_wdata[N_IRQ-1:0] : '0;

  // A CTRL write during a handler lands in the saved copy so reti restores it.
  assign gieWr  = (ctrlWr && (state_q != SERVICE)) ? bus.cfg_wdata[0] : gie_q;
  assign pgieWr = (ctrlWr && (state_q == SERVICE)) ? bus.cfg_wdata[0] : pgie_q;

  always_comb begin
    ackClr = '0;
    if (ackFire) ackClr[irqId_q] = 1'b1;
  end

  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // Edge channels: a new rising edge beats a simultaneous clear.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!mode_q[i])                 pend_d[i] = s2_q[i];
      else if (s2_q[i] && !s3_q[i])   pend_d[i] = 1'b1;
      else if (w1c[i] || ackClr[i])   pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      s1_q   <= bus.irq;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      if (bus.cfg_we && (bus.cfg_addr == 2'd0)) mask_q <= bus.cfg_wdata[N_IRQ-1:0];
      if (bus.cfg_we && (bus.cfg_addr == 2'd1)) mode_q <= bus.cfg_wdata[N_IRQ-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      intReq_q    <= 1'b0;
      inService_q <= 1'b0;
      irqId_q     <= '0;
      vecPc_q     <= '0;
      epc_q       <= '0;
      gie_q       <= 1'b0;
      pgie_q      <= 1'b0;
    end else begin
      gie_q  <= gieWr;
      pgie_q <= pgieWr;
      case (state_q)
        IDLE: begin
          if (bus.at_boundary && gie_q && (|eligible)) begin
            state_q  <= REQ;
            intReq_q <= 1'b1;
            irqId_q  <= winner;
            vecPc_q  <= ADDR_W'(VEC_BASE) + (ADDR_W'(winner) << VEC_SHIFT);
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state_q     <= SERVICE;
            intReq_q    <= 1'b0;
            inService_q <= 1'b1;
            epc_q       <= bus.pc_next;
            pgie_q      <= gieWr;
            gie_q       <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.reti) begin
            state_q     <= IDLE;
            inService_q <= 1'b0;
            gie_q       <= pgieWr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata[N_IRQ-1:0] = mask_q;
      2'd1:    bus.cfg_rdata[N_IRQ-1:0] = mode_q;
      2'd2:    bus.cfg_rdata[N_IRQ-1:0] = pend_q;
      default: bus.cfg_rdata[0]         = gie_q;
    endcase
  end

  assign bus.int_req    = intReq_q;
  assign bus.in_service = inService_q;
  assign bus.irq_id     = irqId_q;
  assign bus.vec_pc     = vecPc_q;
  assign bus.epc        = epc_q;

endmodule

// File: tb/tb_risc_irq_ctrl.sv
// Self-checking bench for risc_irq_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the controller.
module tb_risc_irq_ctrl;
  localparam int          N_IRQ     = 8;
  localparam int          ADDR_W    = 32;
  localparam logic [31:0] VEC_BASE  = 32'h0000_0040;
  localparam int          VEC_SHIFT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  risc_irq_ctrl_if #(.N_IRQ(N_IRQ), .ADDR_W(ADDR_W)) bus ();

  risc_irq_ctrl #(
    .N_IRQ(N_IRQ), .ADDR_W(ADDR_W), .VEC_BASE(VEC_BASE), .VEC_SHIFT(VEC_SHIFT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Behavioural model: samples of irq at the last three edges plus architectural state.
  logic [7:0]  mMask, mMode, mPend, q0, q1, q2;
  bit          mGie, mPgie, mReq, mSvc;
  int          mState;
  logic [2:0]  mId;
  logic [31:0] mVec, mEpc;

  task automatic model_reset();
    mMask = '0; mMode = '0; mPend = '0; q0 = '0; q1 = '0; q2 = '0;
    mGie = 0; mPgie = 0; mReq = 0; mSvc = 0; mState = 0;
    mId = '0; mVec = '0; mEpc = '0;
  endtask

  task automatic idle_inputs();
    bus.irq = '0; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
    bus.at_boundary = 1'b0; bus.pc_next = '0; bus.int_ack = 1'b0; bus.reti = 1'b0;
  endtask

  function automatic logic [7:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return mMask;
      2'd1:    return mMode;
      2'd2:    return mPend;
      default: return {7'd0, mGie};
    endcase
  endfunction

  // One clock: derive the model's next state from the rules, then let the DUT clock.
  task automatic tick();
    logic [7:0]  elig, nPend, w1c, ackClr, nMask, nMode;
    logic [2:0]  nId;
    logic [31:0] nVec, nEpc;
    bit          nGie, nPgie, nReq, nSvc;
    int          nState, win;
    elig = mPend & mMask;
    win = -1;
    for (int i = N_IRQ - 1; i >= 0; i--) if (elig[i]) win = i;
    nMask = mMask; nMode = mMode; nGie = mGie; nPgie = mPgie; nState = mState;
    nReq = mReq; nSvc = mSvc; nId = mId; nVec = mVec; nEpc = mEpc;
    w1c = '0; ackClr = '0;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0: nMask = bus.cfg_wdata[7:0];
        2'd1: nMode = bus.cfg_wdata[7:0];
        2'd2: w1c = bus.cfg_wdata[7:0];
        default: if (mState == 2) nPgie = bus.cfg_wdata[0]; else nGie = bus.cfg_wdata[0];
      endcase
    end
    if (mState == 0 && bus.at_boundary && mGie && win >= 0) begin
      nState = 1; nReq = 1; nId = 3'(win);
      nVec = VEC_BASE + 32'(win) * 32'(1 << VEC_SHIFT);
    end else if (mState == 1 && bus.int_ack) begin
      nState = 2; nReq = 0; nSvc = 1; nEpc = bus.pc_next;
      ackClr[mId] = 1'b1; nPgie = nGie; nGie = 0;
    end else if (mState == 2 && bus.reti) begin
      nState = 0; nSvc = 0; nGie = nPgie;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      if (!mMode[i])                nPend[i] = q1[i];
      else if (q1[i] && !q2[i])     nPend[i] = 1'b1;
      else if (w1c[i] || ackClr[i]) nPend[i] = 1'b0;
      else                          nPend[i] = mPend[i];
    end
    @(posedge clk);
    #1;
    mMask = nMask; mMode = nMode; mPend = nPend; mGie = nGie; mPgie = nPgie;
    mState = nState; mReq = nReq; mSvc = nSvc; mId = nId; mVec = nVec; mEpc = nEpc;
    q2 = q1; q1 = q0; q0 = bus.irq;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic boundary();
    bus.at_boundary = 1'b1; tick(); bus.at_boundary = 1'b0;
  endtask

  task automatic ack(input logic [31:0] pc);
    bus.pc_next = pc; bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
  endtask

  task automatic do_reti();
    bus.reti = 1'b1; tick(); bus.reti = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    bus.irq = m; tick(); bus.irq = '0;
    repeat (3) tick();
  endtask

  task automatic clean_cfg();
    cfg_write(2'd0, 32'h0);
    cfg_write(2'd2, 32'hFF);
  endtask

  task automatic test_reset();
    bit m3;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    compared++; if (bus.int_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_int_req: got %b want 0", bus.int_req); end
    compared++; if (bus.in_service !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_service: got %b want 0", bus.in_service); end
    compared++; if (bus.vec_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_vec_pc: got %h want 0", bus.vec_pc); end
    compared++; if (bus.epc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_epc: got %h want 0", bus.epc); end
    compared++; if (bus.irq_id !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_irq_id: got %0d want 0", bus.irq_id); end
    for (int a = 0; a < 4; a++) begin
      bus.cfg_addr = 2'(a);
      #1;
      compared++;
      if (bus.cfg_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata%0d: got %h want 0", a, bus.cfg_rdata); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    m3 = 1'($urandom_range(1));
    cfg_write(2'd1, {28'd0, m3, 3'd0});
    cfg_write(2'd3, 32'h1);
    pulse_irq(8'h08);
    boundary();
    tick();
    compared++; if (bus.int_req !== 1'b0) begin mismatched++; $display("[TB] FAIL masked_no_req: got %b want 0", bus.int_req); end
    bus.cfg_addr = 2'd2;
    #1;
    compared++;
    if (bus.cfg_rdata !== (m3 ? 32'h8 : 32'h0)) begin
      mismatched++; $display("[TB] FAIL masked_pend3(mode=%0d): got %h want %h", m3, bus.cfg_rdata, m3 ? 32'h8 : 32'h0);
    end
    clean_cfg();
  endtask

  task automatic test_edge();
    clean_cfg();
    cfg_write(2'd1, 32'h08);
    cfg_write(2'd0, 32'h08);
    cfg_write(2'd3, 32'h1);
    bus.cfg_addr = 2'd2;
    bus.irq = 8'h08; tick(); bus.irq = '0;
    compared++; if (bus.cfg_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL edge_pend_k: got %h want 0", bus.cfg_rdata); end
    tick();
    compared++; if (bus.cfg_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL edge_pend_k1: got %h want 0", bus.cfg_rdata); end
    tick();
    compared++; if (bus.cfg_rdata !== 32'h8) begin mismatched++; $display("[TB] FAIL edge_pend_k2: got %h want 8", bus.cfg_rdata); end
    boundary();
    compared++; if (bus.int_req !== 1'b1) begin mismatched++; $display("[TB] FAIL edge_int_req: got %b want 1", bus.int_req); end
    compared++; if (bus.irq_id !== 3'd3) begin mismatched++; $display("[TB] FAIL edge_irq_id: got %0d want 3", bus.irq_id); end
    compared++; if (bus.vec_pc !== 32'h70) begin mismatched++; $display("[TB] FAIL edge_vec_pc: got %h want 70", bus.vec_pc); end
    ack(32'h24);
    compared++; if (bus.epc !== 32'h24) begin mismatched++; $display("[TB] FAIL edge_epc: got %h want 24", bus.epc); end
    compared++; if (bus.cfg_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL edge_pend_acked: got %h want 0", bus.cfg_rdata); end
    compared++; if (bus.in_service !== 1'b1 || bus.int_req !== 1'b0) begin mismatched++; $display("[TB] FAIL edge_service: got svc=%b req=%b want svc=1 req=0", bus.in_service, bus.int_req); end
    bus.cfg_addr = 2'd3; #1;
    compared++; if (bus.cfg_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL edge_gie_cleared: got %h want 0", bus.cfg_rdata); end
    do_reti();
    compared++; if (bus.cfg_rdata !== 32'h1 || bus.in_service !== 1'b0) begin mismatched++; $display("[TB] FAIL edge_reti: got gie=%h svc=%b want gie=1 svc=0", bus.cfg_rdata, bus.in_service); end
    compared++; if (bus.epc !== 32'h24) begin mismatched++; $display("[TB] FAIL edge_epc_hold: got %h want 24", bus.epc); end
  endtask

  task automatic test_priority();
    clean_cfg();
    cfg_write(2'd1, 32'hFF);
    cfg_write(2'd0, 32'hFF);
    pulse_irq(8'h22);
    boundary();
    compared++; if (bus.irq_id !== 3'd1 || bus.vec_pc !== 32'h50) begin mismatched++; $display("[TB] FAIL prio_first: got id=%0d vec=%h want id=1 vec=50", bus.irq_id, bus.vec_pc); end
    ack(32'h100);
    do_reti();
    boundary();
    compared++; if (bus.int_req !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_second_req: got %b want 1", bus.int_req); end
    compared++; if (bus.irq_id !== 3'd5 || bus.vec_pc !== 32'h90) begin mismatched++; $display("[TB] FAIL prio_second: got id=%0d vec=%h want id=5 vec=90", bus.irq_id, bus.vec_pc); end
    ack(32'h104);
    do_reti();
  endtask

  task automatic test_level();
    clean_cfg();
    cfg_write(2'd1, 32'h00);
    cfg_write(2'd0, 32'h04);
    bus.irq = 8'h04;
    repeat (3) tick();
    boundary();
    compared++; if (bus.int_req !== 1'b1 || bus.irq_id !== 3'd2) begin mismatched++; $display("[TB] FAIL level_first: got req=%b id=%0d want req=1 id=2", bus.int_req, bus.irq_id); end
    ack(32'h200);
    do_reti();
    boundary();
    compared++; if (bus.int_req !== 1'b1 || bus.irq_id !== 3'd2) begin mismatched++; $display("[TB] FAIL level_rereq: got req=%b id=%0d want req=1 id=2", bus.int_req, bus.irq_id); end
    ack(32'h204);
    bus.irq = '0;
    repeat (3) tick();
    do_reti();
    boundary();
    tick();
    compared++; if (bus.int_req !== 1'b0) begin mismatched++; $display("[TB] FAIL level_released: got %b want 0", bus.int_req); end
  endtask

  task automatic test_no_nesting();
    clean_cfg();
    cfg_write(2'd1, 32'hFF);
    cfg_write(2'd0, 32'hFF);
    pulse_irq(8'h10);
    boundary();
    compared++; if (bus.irq_id !== 3'd4) begin mismatched++; $display("[TB] FAIL nest_first_id: got %0d want 4", bus.irq_id); end
    ack(32'h300);
    pulse_irq(8'h01);
    boundary();
    compared++; if (bus.int_req !== 1'b0 || bus.in_service !== 1'b1) begin mismatched++; $display("[TB] FAIL nest_blocked: got req=%b svc=%b want req=0 svc=1", bus.int_req, bus.in_service); end
    do_reti();
    boundary();
    compared++; if (bus.int_req !== 1'b1 || bus.irq_id !== 3'd0 || bus.vec_pc !== 32'h40) begin mismatched++; $display("[TB] FAIL nest_after: got req=%b id=%0d vec=%h want req=1 id=0 vec=40", bus.int_req, bus.irq_id, bus.vec_pc); end
    compared++; if (bus.epc !== 32'h300) begin mismatched++; $display("[TB] FAIL nest_epc_hold: got %h want 300", bus.epc); end
    ack(32'h304);
    do_reti();
  endtask

  task automatic test_random();
    logic [7:0] flip;
    clean_cfg();
    cfg_write(2'd1, $urandom);
    cfg_write(2'd0, $urandom | 32'h1);
    cfg_write(2'd3, 32'h1);
    for (int c = 0; c < 1500; c++) begin
      flip = '0;
      for (int b = 0; b < N_IRQ; b++) if ($urandom_range(7) == 0) flip[b] = 1'b1;
      bus.irq = bus.irq ^ flip;
      bus.cfg_we = ($urandom_range(15) == 0);
      bus.cfg_addr = 2'($urandom_range(3));
      bus.cfg_wdata = $urandom;
      if (bus.cfg_addr == 2'd3 && $urandom_range(3) != 0) bus.cfg_wdata[0] = 1'b1;
      bus.at_boundary = ($urandom_range(3) == 0);
      bus.pc_next = $urandom & 32'hFFFF_FFFC;
      bus.int_ack = (mState == 1) ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
      bus.reti = (mState == 2) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      tick();
      compared++; if (bus.int_req !== mReq) begin mismatched++; $display("[TB] FAIL rnd_int_req@%0d: got %b want %b", c, bus.int_req, mReq); end
      compared++; if (bus.in_service !== mSvc) begin mismatched++; $display("[TB] FAIL rnd_in_service@%0d: got %b want %b", c, bus.in_service, mSvc); end
      compared++; if (bus.irq_id !== mId) begin mismatched++; $display("[TB] FAIL rnd_irq_id@%0d: got %0d want %0d", c, bus.irq_id, mId); end
      compared++; if (bus.epc !== mEpc) begin mismatched++; $display("[TB] FAIL rnd_epc@%0d: got %h want %h", c, bus.epc, mEpc); end
      compared++; if (bus.cfg_rdata !== {24'd0, model_rdata(bus.cfg_addr)}) begin mismatched++; $display("[TB] FAIL rnd_rdata%0d@%0d: got %h want %h", bus.cfg_addr, c, bus.cfg_rdata, model_rdata(bus.cfg_addr)); end
      if (mReq) begin
        compared++; if (bus.vec_pc !== mVec) begin mismatched++; $display("[TB] FAIL rnd_vec_pc@%0d: got %h want %h", c, bus.vec_pc, mVec); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_req();
    idle_inputs();
    rst_n = 1'b0; #3; model_reset();
    @(negedge clk); rst_n = 1'b1;
    cfg_write(2'd1, 32'h40);
    cfg_write(2'd0, 32'h40);
    cfg_write(2'd3, 32'h1);
    pulse_irq(8'h40);
    boundary();
    compared++; if (bus.int_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rstreq_setup: got %b want 1", bus.int_req); end
    #2;
    rst_n = 1'b0;
    bus.cfg_addr = 2'd0;
    #1;
    compared++; if (bus.int_req !== 1'b0 || bus.vec_pc !== 32'h0 || bus.irq_id !== 3'd0) begin mismatched++; $display("[TB] FAIL rstreq_async: got req=%b vec=%h id=%0d want all 0", bus.int_req, bus.vec_pc, bus.irq_id); end
    compared++; if (bus.cfg_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rstreq_mask: got %h want 0", bus.cfg_rdata); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      pulse_irq(8'h40 | 8'(1 << r));
      boundary();
      compared++; if (bus.int_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rstreq_quiet%0d: got %b want 0", r, bus.int_req); end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_no_nesting();
    test_random();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/risc_irq_ctrl.md
Name: risc_irq_ctrl

Overview:
- Parametrised N-channel interrupt controller for the multi-cycle RISC core.
- Replaces the single raw INT input to the control unit.
- Synchronises board-level request lines, latches them as edge- or level-sensitive per channel, masks them and resolves fixed priority.
- Hands the control unit a vectored target PC at instruction boundaries, saves the return PC (EPC) and restores it on return-from-interrupt.

Parameters:
- N_IRQ, 8: number of interrupt channels (1..32).
- ADDR_W, 32: PC width.
- VEC_BASE, 32'h0000_0040: PC of the channel-0 handler.
- VEC_SHIFT, 4: handler spacing. vec_pc = VEC_BASE + (id << VEC_SHIFT).
- ID_W, derived as clog2(N_IRQ), minimum 1: width of irq_id.

Ports:
- clk  in  1  system clock (divided core clock).
- rst  in  1  asynchronous, active-low reset.
- irq  in  N_IRQ  raw asynchronous request lines.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select: 0 MASK, 1 MODE, 2 PEND, 3 CTRL.
- cfg_wdata  in  32  config write data. Bits [N_IRQ-1:0] are used.
- cfg_rdata  out  32  combinational read of the selected register, zero-extended.
- at_boundary  in  1  high for one cycle when the control unit is about to update PC.
- pc_next  in  ADDR_W  PC the core would load at this boundary (NPC or branch target).
- int_ack  in  1  control unit has loaded vec_pc into PC.
- reti  in  1  control unit is executing return-from-interrupt.
- int_req  out  1  interrupt request to the control unit.
- vec_pc  out  ADDR_W  handler address. Valid while int_req=1.
- epc  out  ADDR_W  saved return PC.
- irq_id  out  ID_W  channel being requested or serviced.
- in_service  out  1  handler is active.

Behaviour:
- Reset (rst=0, asynchronous):
  - All state clears: synchronisers, MASK, MODE, PEND and GIE (CTRL[0]).
  - FSM goes to IDLE.
  - int_req=0, vec_pc=0, epc=0, irq_id=0, in_service=0.
- Synchroniser: two flops per channel.
  - s2 is the second stage. s3 is the registered copy of s2, used for edge detection.
- Pending logic, per channel i:
  - MODE[i]=1 (edge): PEND[i] sets when s2&~s3.
    - It clears by a W1C write to PEND, or when channel i is acked.
    - If a set and a clear occur in the same cycle, the set wins.
  - MODE[i]=0 (level): PEND[i] = s2 every cycle. Writes to PEND have no effect on that bit.
  - Latency: irq held high before clock edge k gives PEND[i]=1 after edge k+2.
- Eligibility:
  - eligible = PEND & MASK.
  - The winner is the lowest set index (channel 0 is highest priority).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when at_boundary & GIE & |eligible.
    - Latch irq_id = winner and vec_pc = VEC_BASE + (winner << VEC_SHIFT).
    - int_req=1 from the next cycle.
  - REQ: int_req=1. irq_id and vec_pc hold even if PEND changes.
    - On int_ack: latch epc = pc_next (sampled at the ack cycle).
    - Also on int_ack: clear PEND[irq_id] if edge mode, clear GIE, save the old GIE in PGIE (internal).
    - Then go to SERVICE with int_req=0 and in_service=1.
  - SERVICE -> IDLE on reti. GIE is restored from PGIE and in_service goes to 0.
    - epc holds its value until the next ack.
    - No nesting: new requests stay pending.
- MASK change in REQ does not withdraw the request. The core must ack it.
- cfg writes take effect on the next edge.
  - A cfg write to CTRL in SERVICE updates PGIE, not GIE.
- reti in IDLE or REQ is ignored.
- int_ack outside REQ is ignored.
- at_boundary outside IDLE is ignored.
- Reset asserted mid-REQ or mid-SERVICE returns the block to IDLE immediately with all outputs zero.

Test Plan:
- Reset → all outputs and cfg_rdata are zero for every cfg_addr. Pulse irq[3] with MASK=0 → int_req stays 0, and PEND[3] reads 1 only if MODE[3]=1.
- MODE=8'h08, MASK=8'h08, GIE=1. Pulse irq[3] high for 1 cycle, then at_boundary → PEND[3]=1 at edge k+2; int_req=1, irq_id=3, vec_pc=32'h70. Ack with pc_next=32'h24 → epc=32'h24, PEND[3]=0, in_service=1, GIE=0.
- MASK=8'hFF. Assert irq[5] and irq[1] together, both edge mode → first request has irq_id=1. After reti plus the next boundary, the second request has irq_id=5 and vec_pc=32'h90.
- Level channel 2 held high through the handler. Issue reti, then at_boundary → immediate re-request with irq_id=2. Deassert irq[2], reti again → no further request.
- In SERVICE, pulse irq[0] and raise at_boundary → no int_req. After reti and a boundary → int_req with irq_id=0.
- Drop rst during REQ → int_req=0 asynchronously, MASK=0. After rst is released, no request occurs until reconfigured.
